// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, fetch FSM state encoding and word-address helper
// used by the scan-line reader and its pixel FIFO.
package fb_pkg;

  localparam int FB_ADDR_W   = 9;
  localparam int FB_PIXSEL_W = 3;
  localparam int FB_PIX_W    = 4;
  localparam int FB_LINES    = 64;
  localparam int FB_LINE_W   = $clog2(FB_LINES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fb_state_t;

  // Eight 4-bit pixels share one memory word; pixel bits [5:3] pick the word.
  function automatic logic [FB_ADDR_W-1:0] fb_word_addr(
    input logic [FB_LINE_W-1:0] line,
    input logic [5:0]           pix
  );
    return {line, pix[5:3]};
  endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// Pixel FIFO with a registered output stage: storage array read is registered
// into the head register, which presents valid/data directly to the consumer.
module fb_pixel_fifo
  import fb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [FB_PIX_W-1:0]       din,
  input  logic                      pop,
  output logic [FB_PIX_W-1:0]       dout,
  output logic                      valid,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [FB_PIX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]      stor_cnt_reg, count_reg;
  logic                out_valid_reg;
  logic [FB_PIX_W-1:0] out_data_reg;

  logic pop_ok, load_out, stor_empty, bypass, stor_wr, stor_rd;

  always_comb begin
    pop_ok     = pop && out_valid_reg;
    load_out   = !out_valid_reg || pop_ok;
    stor_empty = (stor_cnt_reg == '0);
    // An empty array with a free head slot lets the new pixel skip the array.
    bypass     = load_out && stor_empty && push;
    stor_wr    = push && !bypass;
    stor_rd    = load_out && !stor_empty;
  end

  always_ff @(posedge clk) begin
    if (stor_wr) mem[wr_ptr_reg] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      stor_cnt_reg  <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      if (stor_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (stor_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      stor_cnt_reg <= stor_cnt_reg + (PTR_W + 1)'(stor_wr) - (PTR_W + 1)'(stor_rd);
      count_reg    <= count_reg + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop_ok);
      if (load_out) begin
        if (stor_rd) begin
          out_data_reg  <= mem[rd_ptr_reg];
          out_valid_reg <= 1'b1;
        end else if (bypass) begin
          out_data_reg  <= din;
          out_valid_reg <= 1'b1;
        end else begin
          out_valid_reg <= 1'b0;
        end
      end
    end
  end

  // The reader's credit scheme never pushes into a full FIFO, even with a pop pending.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && count_reg == FULL_CNT));

  assign dout  = out_data_reg;
  assign valid = out_valid_reg;
  assign count = count_reg;

endmodule

// File: rtl/fb_reader.sv
// Scan-line fetcher: issues one framebuffer pixel address per cycle under FIFO
// credit and streams returned pixels out. FB_READER_STATS_EN adds underrun_cnt.
module fb_reader
  import fb_pkg::*;
#(
  parameter int LINE_W     = 64,
  parameter int FIFO_DEPTH = 16,
  parameter int MEM_LAT    = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   bank_sel,
  input  logic                   line_req,
  input  logic [FB_LINE_W-1:0]   line_idx,
  output logic                   busy,
  output logic                   line_done,
  output logic                   overrun,
  output logic                   pix_valid,
  output logic [FB_PIX_W-1:0]    pix_data,
  input  logic                   pix_ready,
  output logic [FB_ADDR_W-1:0]   mem_addr,
  output logic                   mem_bank,
  output logic [FB_PIXSEL_W-1:0] mem_pix_sel,
  input  logic [FB_PIX_W-1:0]    mem_pixel
`ifdef FB_READER_STATS_EN
  ,
  output logic [15:0]            underrun_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CR_W  = CNT_W + 1;
  localparam int INF_W = $clog2(MEM_LAT + 2);
  localparam logic [5:0] LAST_PIX = 6'(LINE_W - 1);

  fb_state_t state_reg, state_next;

  logic [FB_LINE_W-1:0]   line_reg;
  logic [5:0]             pix_cnt_reg;
  logic [MEM_LAT:0]       vsr_reg;
  logic [INF_W-1:0]       inflight;
  logic [CNT_W-1:0]       fifo_count;
  logic                   busy_reg, line_done_reg, overrun_reg;
  logic [FB_ADDR_W-1:0]   mem_addr_reg;
  logic [FB_PIXSEL_W-1:0] mem_pix_sel_reg;
  logic                   mem_bank_reg, bank_pend_reg, bank_pend_valid_reg;

  logic                   accept, credit_ok, issue, last_issue, drain_done;
  logic [FB_LINE_W-1:0]   issue_line;
  logic [5:0]             issue_pix;

  // Stage k of vsr_reg marks an address presented k cycles ago; stage MEM_LAT returns now.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= MEM_LAT; i++) inflight = inflight + INF_W'(vsr_reg[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept)     state_next = FETCH;
      FETCH:   if (last_issue) state_next = DRAIN;
      DRAIN:   if (drain_done) state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  // Pixel 0 issues on the accepting edge so the first address is out the next cycle.
  always_comb begin
    accept     = (state_reg == IDLE) && line_req && !line_done_reg;
    credit_ok  = (CR_W'(fifo_count) + CR_W'(inflight)) < CR_W'(FIFO_DEPTH);
    issue_line = accept ? line_idx : line_reg;
    issue_pix  = accept ? 6'd0 : pix_cnt_reg;
    issue      = credit_ok && (accept || (state_reg == FETCH));
    last_issue = issue && (issue_pix == LAST_PIX);
    drain_done = (state_reg == DRAIN) && (vsr_reg[MEM_LAT-1:0] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_reg        <= '0;
      pix_cnt_reg     <= '0;
      vsr_reg         <= '0;
      mem_addr_reg    <= '0;
      mem_pix_sel_reg <= '0;
    end else begin
      vsr_reg <= {vsr_reg[MEM_LAT-1:0], issue};
      if (accept) line_reg <= line_idx;
      if (issue)       pix_cnt_reg <= issue_pix + 6'd1;
      else if (accept) pix_cnt_reg <= '0;
      if (issue) begin
        mem_addr_reg    <= fb_word_addr(issue_line, issue_pix);
        mem_pix_sel_reg <= issue_pix[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg            <= 1'b0;
      line_done_reg       <= 1'b0;
      overrun_reg         <= 1'b0;
      mem_bank_reg        <= 1'b0;
      bank_pend_reg       <= 1'b0;
      bank_pend_valid_reg <= 1'b0;
    end else begin
      busy_reg      <= (state_next != IDLE);
      line_done_reg <= drain_done;
      if (line_req && !accept) overrun_reg <= 1'b1;
      else if (frame_start)    overrun_reg <= 1'b0;
      // A bank switch requested mid-line waits so the line in flight stays coherent.
      if (frame_start) begin
        if (state_reg == IDLE) begin
          mem_bank_reg        <= bank_sel;
          bank_pend_valid_reg <= 1'b0;
        end else begin
          bank_pend_reg       <= bank_sel;
          bank_pend_valid_reg <= 1'b1;
        end
      end else if ((state_reg == IDLE) && bank_pend_valid_reg) begin
        mem_bank_reg        <= bank_pend_reg;
        bank_pend_valid_reg <= 1'b0;
      end
    end
  end

  fb_pixel_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vsr_reg[MEM_LAT]),
    .din   (mem_pixel),
    .pop   (pix_ready),
    .dout  (pix_data),
    .valid (pix_valid),
    .count (fifo_count)
  );

`ifdef FB_READER_STATS_EN
  logic [15:0] underrun_cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt_reg <= '0;
    end else if (frame_start) begin
      underrun_cnt_reg <= '0;
    end else if (pix_ready && !pix_valid && busy_reg && (underrun_cnt_reg != 16'hFFFF)) begin
      underrun_cnt_reg <= underrun_cnt_reg + 16'd1;
    end
  end

  assign underrun_cnt = underrun_cnt_reg;
`endif

  assign busy        = busy_reg;
  assign line_done   = line_done_reg;
  assign overrun     = overrun_reg;
  assign mem_addr    = mem_addr_reg;
  assign mem_bank    = mem_bank_reg;
  assign mem_pix_sel = mem_pix_sel_reg;

endmodule

// File: tb/tb_fb_reader.sv
// Scoreboard bench for fb_reader: a model framebuffer answers the memory port,
// expected addresses and pixels are queued at request time and checked by a monitor.
module tb_fb_reader;

  parameter int LINE_W     = 64;
  parameter int FIFO_DEPTH = 16;
  parameter int MEM_LAT    = 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start = 1'b0;
  logic       bank_sel = 1'b0;
  logic       line_req = 1'b0;
  logic [5:0] line_idx = 6'd0;
  logic       busy, line_done, overrun, pix_valid, pix_ready;
  logic [3:0] pix_data;
  logic [8:0] mem_addr;
  logic       mem_bank;
  logic [2:0] mem_pix_sel;
  logic [3:0] mem_pixel;
`ifdef FB_READER_STATS_EN
  logic [15:0] underrun_cnt;
`endif

  int tests = 0;
  int errors = 0;
  int cyc = 0;
  int req_cyc = 0;
  int valid_rise_cyc = 0;
  int ready_mode = 0;
  int ready_ph = 0;
  int issued = 0;
  int popped = 0;
  int max_out = 0;
  logic [11:0] prev_as = '0;
  logic        prev_valid = 1'b0;
  logic [12:0] addr_q[$];
  logic [3:0]  exp_q[$];
  logic [3:0]  lat_pipe [MEM_LAT];

  fb_reader #(
    .LINE_W     (LINE_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .MEM_LAT    (MEM_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start  (frame_start),
    .bank_sel     (bank_sel),
    .line_req     (line_req),
    .line_idx     (line_idx),
    .busy         (busy),
    .line_done    (line_done),
    .overrun      (overrun),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_ready    (pix_ready),
    .mem_addr     (mem_addr),
    .mem_bank     (mem_bank),
    .mem_pix_sel  (mem_pix_sel),
    .mem_pixel    (mem_pixel)
`ifdef FB_READER_STATS_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    ready_ph++;
  end

  assign pix_ready = (ready_mode == 0) ? 1'b1 : ((ready_ph % 4) == 0);

  function automatic logic [3:0] fb_model(input int bank, input int line, input int pix);
    return 4'(line * 3 + pix * 5 + bank * 7 + pix / 4);
  endfunction

  // Board memory: pixel for the presented address is valid MEM_LAT cycles later.
  always @(posedge clk) begin
    lat_pipe[0] <= fb_model(int'(mem_bank), int'(mem_addr[8:3]),
                            int'({mem_addr[2:0], mem_pix_sel}));
    for (int k = 1; k < MEM_LAT; k++) lat_pipe[k] <= lat_pipe[k-1];
  end
  assign mem_pixel = lat_pipe[MEM_LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [11:0] cur;
    logic [12:0] exp_a;
    int outstanding;
    cur = {mem_addr, mem_pix_sel};
    if (!rst_n) begin
      issued = 0;
      popped = 0;
    end else begin
      if (cur != prev_as) begin
        issued++;
        if (addr_q.size() == 0) begin
          tests++;
          errors++;
          $display("[TB] FAIL unexpected_issue: got 0x%0h, expected none", {mem_bank, cur});
        end else begin
          exp_a = addr_q.pop_front();
          check("issue_addr", 32'({mem_bank, cur}), 32'(exp_a));
        end
      end
      outstanding = issued - popped;
      if (outstanding > max_out) max_out = outstanding;
      if (pix_valid && !prev_valid) valid_rise_cyc = cyc;
      if (pix_valid && pix_ready) begin
        popped++;
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("[TB] FAIL unexpected_pixel: got 0x%0h, expected none", pix_data);
        end else begin
          check("pixel", 32'(pix_data), 32'(exp_q.pop_front()));
        end
      end
    end
    prev_as = cur;
    prev_valid = pix_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int line, input int bank);
    for (int p = 0; p < LINE_W; p++) begin
      exp_q.push_back(fb_model(bank, line, p));
      addr_q.push_back({1'(bank), 6'(line), 3'(p / 8), 3'(p % 8)});
    end
    line_idx = 6'(line);
    line_req = 1'b1;
    req_cyc  = cyc;
    tick();
    line_req = 1'b0;
  endtask

  task automatic wait_done(input int line, output int rel);
    bit found;
    found = 1'b0;
    rel = -1;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk);
      if (line_done) begin
        found = 1'b1;
        rel = cyc - req_cyc;
      end
    end
    if (!found) begin
      tests++;
      errors++;
      $display("[TB] FAIL line_done_timeout: got no line_done, expected one for line %0d", line);
    end else begin
      $display("[TB] line %0d fetched, line_done in cycle %0d, first pix_valid in cycle %0d",
               line, rel, valid_rise_cyc - req_cyc);
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_pixels_left", 32'(exp_q.size()), 32'd0);
    check("drain_addrs_left", 32'(addr_q.size()), 32'd0);
    tick();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_line_done"}, 32'(line_done), 32'd0);
    check({tag, "_overrun"}, 32'(overrun), 32'd0);
    check({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    check({tag, "_pix_data"}, 32'(pix_data), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_bank"}, 32'(mem_bank), 32'd0);
    check({tag, "_mem_pix_sel"}, 32'(mem_pix_sel), 32'd0);
`ifdef FB_READER_STATS_EN
    check({tag, "_underrun_cnt"}, 32'(underrun_cnt), 32'd0);
`endif
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int rel;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("por");
    tick();
    rst_n = 1'b1;
    tick();

    // Unthrottled line 5, bank 0
    do_req(5, 0);
    wait_done(5, rel);
    check("t1_done_cycle", 32'(rel), 32'(LINE_W + 1 + MEM_LAT));
    check("t1_first_valid", 32'(valid_rise_cyc - req_cyc), 32'(2 + MEM_LAT));
    wait_drain();

    // Consumer ready one cycle in four
    max_out = 0;
    ready_mode = 1;
    do_req(9, 0);
    wait_done(9, rel);
    check("t2_first_valid", 32'(valid_rise_cyc - req_cyc), 32'(2 + MEM_LAT));
    ready_mode = 0;
    wait_drain();
    check("t2_max_outstanding", 32'(max_out), 32'(FIFO_DEPTH));

    // Second request mid-fetch is ignored and flagged
    do_req(12, 0);
    repeat (9) tick();
    line_idx = 6'd20;
    line_req = 1'b1;
    tick();
    line_req = 1'b0;
    @(negedge clk);
    check("t3_overrun_set", 32'(overrun), 32'd1);
    wait_done(12, rel);
    check("t3_done_cycle", 32'(rel), 32'(LINE_W + 1 + MEM_LAT));
    wait_drain();
    check("t3_overrun_sticky", 32'(overrun), 32'd1);
    bank_sel = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("t3_overrun_cleared", 32'(overrun), 32'd0);
    tick();

    // Bank switch mid-line is deferred to the next line
    do_req(7, 0);
    repeat (19) tick();
    bank_sel = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("t4_bank_held", 32'(mem_bank), 32'd0);
    wait_done(7, rel);
    wait_drain();
    @(negedge clk);
    check("t4_bank_applied", 32'(mem_bank), 32'd1);
    tick();
    do_req(8, 1);
    repeat (LINE_W + MEM_LAT) tick();
    line_idx = 6'd30;
    line_req = 1'b1;
    @(negedge clk);
    check("t4_done_same_cycle", 32'(line_done), 32'd1);
    check("t4_first_valid", 32'(valid_rise_cyc - req_cyc), 32'(2 + MEM_LAT));
    tick();
    line_req = 1'b0;
    @(negedge clk);
    check("t4_same_cycle_overrun", 32'(overrun), 32'd1);
    check("t4_same_cycle_not_busy", 32'(busy), 32'd0);
    wait_drain();

    // Reset around pixel 30 aborts the line
    do_req(3, 1);
    repeat (29) tick();
    rst_n = 1'b0;
    exp_q.delete();
    addr_q.delete();
    @(negedge clk);
    check_reset("midline");
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("t5_fifo_empty", 32'(pix_valid), 32'd0);
    tick();
    do_req(3, 0);
    wait_done(3, rel);
    check("t5_done_cycle", 32'(rel), 32'(LINE_W + 1 + MEM_LAT));
    wait_drain();

`ifdef FB_READER_STATS_EN
    // Underrun cycles while busy: from the first address until the first pixel
    bank_sel = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    @(negedge clk);
    check("t6_cnt_cleared", 32'(underrun_cnt), 32'd0);
    tick();
    do_req(10, 0);
    wait_done(10, rel);
    wait_drain();
    check("t6_underrun_cycles", 32'(underrun_cnt), 32'(MEM_LAT + 1));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/fb_reader.md
# fb_reader

Chip-side initiator for the external framebuffer memory port: fetches one 64-pixel, 4 bpp scan line on request and streams the pixels to the video pipeline through a ready/valid FIFO. It drives the word address, bank and nibble-select lines that the board-level memory responder decodes, and captures the returned 4-bit pixel after a fixed latency. Framebuffer geometry: 64×64 pixels per bank, 8 pixels per word, two banks for double buffering.

## Interface
Parameters:
- `LINE_W`, 64: pixels per line; multiple of 8, max 64.
- `FIFO_DEPTH`, 16: pixel FIFO entries; power of two, ≥ 4.
- `MEM_LAT`, 1: cycles from address presented to `mem_pixel` valid; 1–4.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `frame_start` in 1: pulse; latches `bank_sel` for the frame.
- `bank_sel` in 1: bank to display next frame.
- `line_req` in 1: pulse; start fetch of line `line_idx`.
- `line_idx` in 6: line number 0–63.
- `busy` out 1: fetch in progress.
- `line_done` out 1: one-cycle pulse when last pixel of line is written to FIFO.
- `overrun` out 1: sticky; `line_req` arrived while busy. Cleared by `frame_start`.
- `pix_valid` out 1, `pix_data` out 4, `pix_ready` in 1: pixel stream, transfer when valid & ready.
- `mem_addr` out 9: word address `{line_idx, pix[5:3]}`.
- `mem_bank` out 1: latched bank.
- `mem_pix_sel` out 3: nibble select `pix[2:0]`.
- `mem_pixel` in 4: returned pixel.
- `underrun_cnt` out 16: only with `FB_READER_STATS_EN`.

## Operation
- FSM states: IDLE, FETCH, DRAIN.
- IDLE: on `line_req`, latch `line_idx`, clear pixel counter, go FETCH. `busy`=1 from next cycle.
- FETCH: each cycle, issue one address if `fifo_count + inflight < FIFO_DEPTH` (no credit for same-cycle pop). On issue, the pixel counter increments. After issuing pixel `LINE_W-1`, go DRAIN.
- DRAIN: wait until `inflight`=0; then `line_done` pulse, go IDLE.
- Return path: an `MEM_LAT`-deep valid shift register tracks issued addresses; at its output `mem_pixel` is written to the FIFO. Overflow impossible by credit rule; any write to a full FIFO is a design error (assert).
- `line_req` in FETCH/DRAIN: ignored, `overrun` set. `line_req` on the same cycle as `line_done`: ignored and flagged.
- `frame_start`: `mem_bank` takes `bank_sel` next cycle. If busy, the bank change is deferred until return to IDLE; the current line keeps its bank.
- `frame_start` does not flush the FIFO; the consumer drains it.
- When idle, address outputs hold their last value.

## Timing
- Reset values: `busy`=0, `line_done`=0, `overrun`=0, `pix_valid`=0, `pix_data`=0, `mem_addr`=0, `mem_bank`=0, `mem_pix_sel`=0, `underrun_cnt`=0; FSM in IDLE; FIFO empty; in-flight cleared.
- All outputs are registered.
- For `line_req` in cycle 0, the first address is presented in cycle 1.
- `mem_pixel` is sampled at the end of cycle 1+`MEM_LAT`.
- `pix_valid` rises in cycle 2+`MEM_LAT` (cycle 3 at default).
- Throughput is 1 pixel/cycle when the consumer is always ready. An unthrottled line completes `line_done` in cycle `LINE_W`+1+`MEM_LAT`.
- Reset mid-line aborts immediately. No partial pixels remain after release.

## Configuration
- `FB_READER_STATS_EN` defined:
  - `underrun_cnt` port present.
  - The counter increments each cycle that `pix_ready`=1, `pix_valid`=0 and `busy`=1.
  - It saturates at 0xFFFF and clears on `frame_start`.
- Not defined: the port and counter are absent; behaviour is otherwise identical.

## Structure
- Shared package `fb_pkg` holds:
  - `FB_ADDR_W`=9, `FB_PIXSEL_W`=3, `FB_PIX_W`=4, `FB_LINES`=64.
  - The `fb_state_t` enum (IDLE, FETCH, DRAIN).
  - The address-composition function.
- Sub-module `fb_pixel_fifo`: synchronous FIFO, parameter `DEPTH`, 4-bit data, push/pop, `count` output, async active-low reset.

## Test plan
- Single line, ready always 1, `line_idx`=5, bank 0:
  - addresses 40..47 appear, each with `mem_pix_sel` 0..7 in order.
  - 64 pixels match model memory.
  - `line_done` in cycle 66.
- Back-pressure: `pix_ready` toggled 1-in-4:
  - `inflight + fifo_count` never exceeds 16.
  - No pixel is lost or duplicated.
  - Order is preserved.
- `MEM_LAT`=3 build: first `pix_valid` in cycle 5; all 64 pixels correct.
- Second `line_req` at cycle 10 of a fetch:
  - ignored, `overrun`=1.
  - `frame_start` clears the flag.
- `frame_start` with `bank_sel`=1 mid-line: current line stays bank 0; the next line issues with `mem_bank`=1.
- `rst_n` low at pixel 30, then release:
  - all outputs at reset values, FIFO empty.
  - A new `line_req` fetches the full line correctly.
  - With stats enabled, an empty FIFO under ready counts the underrun cycles exactly.
